// File: rtl/ram_16x8_if.sv
// Access bus for the 16x8 RAM: enable, write enable, address, write data
// and registered read data.
interface ram_16x8_if;
  logic       en;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  // Datapath side drives the access, RAM returns read data
  modport master (output en, output we, output addr, output din, input dout);
  modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/ram_16x8.sv
// 16-word x 8-bit single-port synchronous RAM. Registered read, write-through
// on write, global access enable, asynchronous active-high clear of the whole
// array and the read register.
module ram_16x8 (
  input  logic       clk,
  input  logic       areset,
  ram_16x8_if.slave  bus
);

  logic [15:0][7:0] mem_q, mem_d;
  logic [7:0]       dout_q, dout_d;

  // Next-state: hold unless enabled; a write also lands on dout (write-first)
  always_comb begin
    mem_d  = mem_q;
    dout_d = dout_q;
    if (bus.en) begin
      if (bus.we) begin
        mem_d[bus.addr] = bus.din;
        dout_d          = bus.din;
      end else begin
        dout_d = mem_q[bus.addr];
      end
    end
  end

  // State register; reset clears every word so unwritten reads return 0x00
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem_q  <= '0;
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_ram_16x8.sv
// Directed self-checking bench for ram_16x8.
module tb_ram_16x8;

  logic clk;
  logic areset;
  int   checks;
  int   errors;

  ram_16x8_if bus ();

  ram_16x8 dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one access, advance one rising edge, then sample 1 time unit later
  task automatic step(input logic en, input logic we, input logic [3:0] addr,
                      input logic [7:0] din);
    bus.en   = en;
    bus.we   = we;
    bus.addr = addr;
    bus.din  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    areset   = 1'b1;
    bus.en   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 4'h0;
    bus.din  = 8'h00;

    // Reset held for several edges
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", bus.dout, 8'h00);
    areset = 1'b0;

    // First edge after release: normal read of never-written word
    step(1, 0, 4'd3, 8'h00);  chk("rd3_after_reset", bus.dout, 8'h00);

    // Writes with write-through
    step(1, 1, 4'd0, 8'hFF);  chk("wr0_thru", bus.dout, 8'hFF);
    step(1, 1, 4'd1, 8'h12);  chk("wr1_thru", bus.dout, 8'h12);
    step(1, 1, 4'd9, 8'hC0);  chk("wr9_thru", bus.dout, 8'hC0);

    // Readback
    step(1, 0, 4'd1, 8'h00);  chk("rd1", bus.dout, 8'h12);
    step(1, 0, 4'd3, 8'h00);  chk("rd3", bus.dout, 8'h00);
    step(1, 0, 4'd9, 8'h00);  chk("rd9", bus.dout, 8'hC0);

    // Enable gating
    step(1, 1, 4'd5, 8'hA4);  chk("wr5_thru", bus.dout, 8'hA4);
    step(0, 1, 4'd6, 8'h1D);  chk("en0_wr_hold", bus.dout, 8'hA4);
    step(0, 0, 4'd6, 8'h00);  chk("en0_rd6_hold", bus.dout, 8'hA4);
    step(0, 0, 4'd1, 8'h00);  chk("en0_rd1_hold", bus.dout, 8'hA4);
    step(1, 0, 4'd6, 8'h00);  chk("rd6_blocked", bus.dout, 8'h00);

    // Load a nonzero dout, then assert reset mid-cycle with no edge
    step(1, 0, 4'd5, 8'h00);  chk("rd5_pre_reset", bus.dout, 8'hA4);
    bus.en = 1'b0;
    #3 areset = 1'b1;
    #1 chk("async_clear_dout", bus.dout, 8'h00);
    #10 areset = 1'b0;
    step(1, 0, 4'd3, 8'h00);  chk("rd3_post_clear", bus.dout, 8'h00);
    step(1, 0, 4'd5, 8'h00);  chk("rd5_post_clear", bus.dout, 8'h00);
    step(1, 0, 4'd9, 8'h00);  chk("rd9_post_clear", bus.dout, 8'h00);

    // Read-after-write on the same address
    step(1, 1, 4'd15, 8'h5A); chk("wr15_5a", bus.dout, 8'h5A);
    step(1, 0, 4'd15, 8'h00); chk("rd15_5a", bus.dout, 8'h5A);
    step(1, 1, 4'd15, 8'h3C); chk("wr15_3c", bus.dout, 8'h3C);
    step(1, 0, 4'd0, 8'h00);  chk("rd0_cleared", bus.dout, 8'h00);
    step(1, 0, 4'd15, 8'h00); chk("rd15_3c", bus.dout, 8'h3C);

    // Write edge while reset is held is lost
    areset = 1'b1;
    step(1, 1, 4'd2, 8'h77);  chk("wr_in_reset_dout", bus.dout, 8'h00);
    areset = 1'b0;
    step(1, 0, 4'd2, 8'h00);  chk("rd2_lost_write", bus.dout, 8'h00);
    step(1, 0, 4'd15, 8'h00); chk("rd15_after_reset", bus.dout, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_16x8.md
# ram_16x8

Single-port 16-word × 8-bit synchronous RAM with an asynchronous clear. It is the data/program storage element of the mini-CPU, addressed directly by the datapath. All accesses are gated by a global enable. Reads are registered, so the datapath sees data one clock edge after presenting the address.

## Interface

Parameters: none. Depth is fixed at 16 words and width at 8 bits.

- `clk` input, 1 bit: the only clock; all state changes on its rising edge except reset.
- `areset` input, 1 bit: reset is asynchronous and active-high. Clears the whole array and `dout`.
- `en` input, 1 bit: access enable; when low, no read or write occurs.
- `we` input, 1 bit: write enable; qualified by `en`.
- `addr` input, 4 bits: word address 0–15.
- `din` input, 8 bits: write data.
- `dout` output, 8 bits: registered read data.

## Operation

- Storage is `mem[0..15]`, 8 bits each.
- While `areset`=1, regardless of `clk`:
  - all 16 words are 0x00
  - `dout` = 0x00
  - writes are ignored
- Reset takes effect immediately on assertion.
- Memory contents are therefore defined (0x00) for any address that has not been written since the last reset.
- At a rising `clk` edge with `areset`=0:
  - `en`=0: memory and `dout` hold; `we`, `addr` and `din` are don't-care.
  - `en`=1, `we`=1: `mem[addr]` ← `din`, and `dout` ← `din` (write-first/write-through).
  - `en`=1, `we`=0: `dout` ← `mem[addr]`; memory unchanged.
- All 4 address bits are used; there is no out-of-range address and no wrap logic.
- No combinational path from any input to `dout`.

## Timing

- Write latency: data is stored at the enabled rising edge. A read of the same address at the next edge returns the new data.
- Read latency: 1 cycle. `dout` reflects the `addr` sampled at the rising edge and is stable until the next enabled edge.
- Write-through: on a write edge, `dout` shows `din` after that same edge.
- Dropping `en` freezes `dout` at its last value. Re-asserting `en` resumes normal access at the next edge.
- Reset mid-operation:
  - Asserting `areset` between edges zeroes `dout` and the array immediately.
  - A write edge coinciding with `areset`=1 is lost.
- Reset release: the first edge with `areset`=0 performs a normal access per `en`/`we`.
- Inputs must meet setup/hold around the rising `clk` edge. Changing them mid-cycle is legal.

## Test plan

- Reset/defaults:
  - Hold `areset`=1 for more than 1 cycle → `dout`=0x00.
  - Release, then read addr 3 with `en`=1, `we`=0 → `dout`=0x00 one edge later.
- Writes and readback:
  - With `en`=1, `we`=1, write addr0=0xFF, addr1=0x12, addr9=0xC0 on successive edges → `dout` follows 0xFF, 0x12, 0xC0 (write-through).
  - Then set `we`=0 and read addr 1, 3, 9 → 0x12, 0x00, 0xC0.
- Enable gating:
  - Write addr5=0xA4 with `en`=1.
  - Then set `en`=0 and apply `we`=1, addr6, din=0x1D for 1 cycle → `dout` holds 0xA4.
  - Apply `we`=0 with addr 6, then addr 1 → `dout` still 0xA4.
  - Set `en`=1, `we`=0, read addr 6 → 0x00, proving the write was blocked.
- Asynchronous reset clears memory:
  - After the above, pulse `areset` for 1 cycle, asserted mid-cycle → `dout` goes to 0x00 immediately, without a clock edge.
  - Read addr 3 and addr 5 → 0x00 and 0x00 (0xA4 erased).
- Read-after-write, same address:
  - Write addr 15=0x5A, next edge read addr 15 → 0x5A.
  - Write addr 15=0x3C, then read addr 0 → 0xFF if written since reset, otherwise 0x00.
- Reset during a write:
  - Hold `areset`=1 across an edge with `en`=1, `we`=1, addr 2, din=0x77.
  - Release and read addr 2 → 0x00.
